z_ing_dispatch_master: RTL
==========================

Z_ING_DISPATCH_MASTER -- requirements
Module: z_ing_dispatch_master

Interface
REQ-001 Parameter: NUM, default test_package::NUM, number of output channels (legal range 2..16).
REQ-002 Parameter: DEPTH, default 4, FIFO entries (power of two, at least 2).
REQ-003 clock  input  1  single clock for all logic.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_z  input  z_ing  record offered for dispatch.
REQ-006 in_valid  input  1  in_z is valid this cycle.
REQ-007 in_ready  output  1  block accepts in_z this cycle.
REQ-008 m_inf  data_inf_c.master  [NUM-1:0]  output channels (valid/ready/data); data = packed in_z, zero-extended to the channel data width.
REQ-009 sent_cnt  output  10  count of completed output handshakes, wraps 1023->0.
REQ-010 fifo_cnt  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-011 Input handshake: a record is written when in_valid && in_ready on a rising clock.
REQ-012 in_ready = (fifo_cnt < DEPTH), combinational from registered state only; no dependence on in_valid or any m_inf.ready.
REQ-013 Full boundary: with fifo_cnt == DEPTH, in_ready = 0 even if an output handshake occurs the same cycle (no write-through).
REQ-014 Empty boundary: with fifo_cnt == 0, every m_inf[i].valid = 0 (no bypass); minimum in-to-out latency is 1 cycle.
REQ-015 Dispatch: only channel rr_ptr may assert valid; m_inf[rr_ptr].valid = (fifo_cnt != 0), and its data = FIFO head; all other channels drive valid = 0, data = 0.
REQ-016 Once valid is asserted, valid and data on that channel hold stable until ready is sampled high.
REQ-017 On an output handshake (m_inf[rr_ptr].valid && ready): pop the head, rr_ptr advances by 1 (NUM-1 wraps to 0), and sent_cnt increments.
REQ-018 Ready on a non-selected channel is ignored and changes no state.
REQ-019 Simultaneous push and pop: fifo_cnt is unchanged; pointers both advance; ordering is preserved.
REQ-020 FIFO order is strictly first-in, first-out; records are never dropped or duplicated.
REQ-021 State machine, 2 states: EMPTY (fifo_cnt == 0) and HOLD (fifo_cnt > 0). EMPTY->HOLD on push without pop; HOLD->EMPTY on pop at fifo_cnt == 1 without push; otherwise the state is held.

Reset
REQ-022 While rst_n = 0: FIFO read/write pointers = 0, fifo_cnt = 0, rr_ptr = 0, sent_cnt = 0, state = EMPTY, all m_inf valid/data = 0, in_ready = 1.
REQ-023 Reset asserted mid-transfer discards all FIFO contents and the pending output beat; after release, dispatch restarts at channel 0.
REQ-024 Reset is applied asynchronously and released synchronously to clock via the existing codebase reset handling; no other block logic uses rst_n.

Structure
REQ-025 z_ing and NUM come from test_package; the block SHALL NOT redefine them locally.
REQ-026 The FIFO is a sub-module z_ing_fifo (parameter DEPTH; ports: push, pop, wdata, rdata, count); the dispatch and round-robin logic sit in the top module.
REQ-027 The implementation is 120-400 lines of RTL with no vendor primitives.

Verification
REQ-028 Reset, then one push with in_z.op = 1, all ready = 1 -> m_inf[0].valid for exactly 1 cycle at T+1; sent_cnt = 1; rr_ptr = 1.
REQ-029 Push 4 records (DEPTH = 4) with all ready = 0 -> fifo_cnt = 4, in_ready = 0; 5th offered record is not accepted; m_inf[0] data is stable throughout.
REQ-030 NUM = 5, 12 back-to-back records with all ready = 1 -> records delivered on channels 0,1,2,3,4,0,1,2,3,4,0,1 in order; sent_cnt = 12.
REQ-031 FIFO full, same cycle m_inf[rr_ptr].ready = 1 and in_valid = 1 -> pop occurs, push is refused, and fifo_cnt = 3 the next cycle.
REQ-032 Assert rst_n = 0 while fifo_cnt = 3 and valid is pending -> all valid = 0 immediately (asynchronously); after release, fifo_cnt = 0, rr_ptr = 0, sent_cnt = 0.
REQ-033 Send 1030 records -> sent_cnt wraps and reads 6.

Source files
------------

// File: rtl/test_package.sv
// Shared codebase definitions: the z_ing record, the default channel count
// and the channel data width.
package test_package;

  localparam int NUM   = 5;
  localparam int DSIZE = 32;

  typedef struct packed {
    logic [3:0]  op;
    logic [7:0]  tag;
    logic [15:0] payload;
  } z_ing;

endpackage

// File: rtl/z_ing_dispatch_master_pkg.sv
// Local definitions for the dispatch block: FSM encoding and counter width.
package z_ing_dispatch_master_pkg;

  localparam int SENT_W = 10;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } disp_state_e;

endpackage

// File: rtl/data_inf_c.sv
// Valid/ready/data channel used by the dispatch outputs.
interface data_inf_c;

  logic                          valid;
  logic                          ready;
  logic [test_package::DSIZE-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/z_ing_fifo.sv
// Synchronous FIFO of z_ing records. Head is presented combinationally on
// rdata; push while full and pop while empty are ignored.
module z_ing_fifo
  import z_ing_dispatch_master_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  test_package::z_ing     wdata,
  output test_package::z_ing     rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_FULL = DEPTH[AW:0];

  test_package::z_ing r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign w_do_push = push && (r_count != LP_FULL);
  assign w_do_pop  = pop  && (r_count != '0);

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; power-of-two depth wraps naturally.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/z_ing_dispatch_master.sv
// Buffers z_ing records in a FIFO and deals them out round-robin, one record
// per output channel, starting at channel 0 after reset.
module z_ing_dispatch_master
  import z_ing_dispatch_master_pkg::*;
#(
  parameter int NUM   = test_package::NUM,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  test_package::z_ing     in_z,
  input  logic                   in_valid,
  output logic                   in_ready,
  data_inf_c.master              m_inf [NUM-1:0],
  output logic [SENT_W-1:0]      sent_cnt,
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = $clog2(NUM);
  localparam logic [CW-1:0] LP_FULL = DEPTH[CW-1:0];
  localparam logic [RW-1:0] LP_LAST = RW'(NUM - 1);
  localparam int DW = test_package::DSIZE;

  disp_state_e         r_state;
  logic [RW-1:0]       r_rr_ptr;
  logic [SENT_W-1:0]   r_sent_cnt;
  logic [CW-1:0]       w_count;
  test_package::z_ing  w_head;
  logic [NUM-1:0]      w_ready;
  logic [NUM-1:0]      w_sel;
  logic                w_push;
  logic                w_pop;
  logic                w_head_valid;

  // Ready depends only on registered occupancy, so a full FIFO refuses a
  // write even when the head leaves in the same cycle.
  assign in_ready     = (w_count < LP_FULL);
  assign w_push       = in_valid && in_ready;
  assign w_head_valid = (r_state == ST_HOLD);
  assign w_pop        = w_head_valid && w_ready[r_rr_ptr];

  z_ing_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (in_z),
    .rdata (w_head),
    .count (w_count)
  );

  // Only the selected channel carries the head; the rest stay idle at zero.
  for (genvar g = 0; g < NUM; g++) begin : g_ch
    assign w_sel[g]       = w_head_valid && (r_rr_ptr == RW'(g));
    assign m_inf[g].valid = w_sel[g];
    assign m_inf[g].data  = w_sel[g] ? DW'(w_head) : '0;
    assign w_ready[g]     = m_inf[g].ready;
  end

  // EMPTY/HOLD tracker mirroring FIFO occupancy; HOLD drives output valid.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_push && !w_pop) r_state <= ST_HOLD;
        ST_HOLD:  if (w_pop && !w_push && (w_count == CW'(1))) r_state <= ST_EMPTY;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

  // Round-robin pointer and handshake counter advance on each completed beat.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_sent_cnt <= '0;
    end else if (w_pop) begin
      r_rr_ptr   <= (r_rr_ptr == LP_LAST) ? '0 : r_rr_ptr + 1'b1;
      r_sent_cnt <= r_sent_cnt + 1'b1;
    end
  end

  assign sent_cnt = r_sent_cnt;
  assign fifo_cnt = w_count;

endmodule
